pspin_cmd_dispatcher: RTL and testbench

- Shares the command interfaces (host-direct, NIC outbound, eDMA) among the clusters' command sources.
- Arbitrates `pspin_cmd_t` requests round-robin and routes each by `intf_id` into a registered per-interface slot.
- Enforces a per-cluster in-flight limit.
- Returns `pspin_cmd_resp_t` completions from the interfaces to the issuing cluster, selected by `cmd_id.cluster_id`.

---
 rtl/pspin_cmd_dispatcher.sv | 213 +++++++++++++++++++++
 tb/tb_pspin_cmd_dispatcher.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pspin_cmd_dispatcher.sv
// Command dispatcher: round-robin arbitration of cluster commands into per-interface
// slots with per-cluster credit limiting, plus a single-stage completion return path.
package pspin_cfg_pkg;
  localparam int NUM_CLUSTERS       = 2;
  localparam int NUM_CMD_INTERFACES = 3;
  localparam int NUM_CORES          = 8;
  localparam int NUM_HPU_CMDS       = 4;

  typedef struct packed {
    logic [1:0] cluster_id;
    logic [3:0] core_id;
    logic [1:0] local_id;
  } pspin_cmd_id_t;

  typedef struct packed {
    pspin_cmd_id_t cmd_id;
    logic [1:0]    intf_id;
    logic [31:0]   descr;
  } pspin_cmd_t;

  typedef struct packed {
    pspin_cmd_id_t cmd_id;
    logic [7:0]    status;
  } pspin_cmd_resp_t;
endpackage

module pspin_cmd_dispatcher
  import pspin_cfg_pkg::*;
#(
  parameter int N_CLUSTERS   = pspin_cfg_pkg::NUM_CLUSTERS,
  parameter int N_INTF       = pspin_cfg_pkg::NUM_CMD_INTERFACES,
  parameter int MAX_INFLIGHT = pspin_cfg_pkg::NUM_CORES * pspin_cfg_pkg::NUM_HPU_CMDS
) (
  input  logic                                              clk_i,
  input  logic                                              rst_ni,
  input  logic [N_CLUSTERS-1:0]                             cmd_valid_i,
  output logic [N_CLUSTERS-1:0]                             cmd_ready_o,
  input  logic [N_CLUSTERS*$bits(pspin_cmd_t)-1:0]          cmd_i,
  output logic [N_INTF-1:0]                                 intf_valid_o,
  input  logic [N_INTF-1:0]                                 intf_ready_i,
  output logic [N_INTF*$bits(pspin_cmd_t)-1:0]              intf_cmd_o,
  input  logic [N_INTF-1:0]                                 intf_resp_valid_i,
  output logic [N_INTF-1:0]                                 intf_resp_ready_o,
  input  logic [N_INTF*$bits(pspin_cmd_resp_t)-1:0]         intf_resp_i,
  output logic [N_CLUSTERS-1:0]                             clu_resp_valid_o,
  input  logic [N_CLUSTERS-1:0]                             clu_resp_ready_i,
  output logic [$bits(pspin_cmd_resp_t)-1:0]                clu_resp_o,
  output logic [N_CLUSTERS*$clog2(MAX_INFLIGHT+1)-1:0]      inflight_o,
  output logic                                              err_bad_intf_o,
  output logic                                              err_bad_cluster_o
);
  localparam int CMD_W = $bits(pspin_cmd_t);
  localparam int RSP_W = $bits(pspin_cmd_resp_t);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int RQ_W  = (N_CLUSTERS > 1) ? $clog2(N_CLUSTERS) : 1;
  localparam int RS_W  = (N_INTF > 1) ? $clog2(N_INTF) : 1;

  function automatic int rr_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

  pspin_cmd_t          cmd      [N_CLUSTERS];
  pspin_cmd_resp_t     resp_in  [N_INTF];
  logic [CNT_W-1:0]    inflight [N_CLUSTERS];
  logic [N_CLUSTERS-1:0] req_bad, req_elig, req_gnt, tgt_free, cred_inc, dlv, underflow;
  logic [N_INTF-1:0]   slot_valid, slot_free, rsp_gnt;
  logic [N_CLUSTERS-1:0] rsp_vec_reg, rsp_onehot;
  logic [RQ_W-1:0]     rr_req_reg, rr_req_next;
  logic [RS_W-1:0]     rr_rsp_reg, rr_rsp_next;
  pspin_cmd_t          gnt_cmd;
  pspin_cmd_resp_t     rsp_sel, rsp_reg;
  logic                req_any, gnt_bad, rsp_any, rsp_sel_bad, rsp_drain, rsp_free;
  logic                err_bad_intf_reg, err_bad_cluster_reg;

  assign slot_free = ~slot_valid | intf_ready_i;

  // Request side: per-cluster eligibility and credit counters.
  for (genvar gi = 0; gi < N_CLUSTERS; gi++) begin : g_clu
    logic [CNT_W-1:0] cnt_reg;
    assign cmd[gi]       = cmd_i[gi*CMD_W +: CMD_W];
    assign req_bad[gi]   = int'(cmd[gi].intf_id) >= N_INTF;
    assign req_elig[gi]  = cmd_valid_i[gi] &
                           (req_bad[gi] | ((cnt_reg < CNT_W'(MAX_INFLIGHT)) & tgt_free[gi]));
    assign cred_inc[gi]  = req_gnt[gi] & ~req_bad[gi];
    assign dlv[gi]       = rsp_vec_reg[gi] & clu_resp_ready_i[gi];
    assign underflow[gi] = dlv[gi] & (cnt_reg == '0);
    assign inflight[gi]  = cnt_reg;
    assign inflight_o[gi*CNT_W +: CNT_W] = cnt_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_reg <= '0;
      end else if (cred_inc[gi] && !(dlv[gi] && !underflow[gi])) begin
        cnt_reg <= cnt_reg + 1'b1;
      end else if (!cred_inc[gi] && dlv[gi] && !underflow[gi]) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < N_CLUSTERS; c++) begin
      tgt_free[c] = 1'b0;
      for (int t = 0; t < N_INTF; t++) begin
        if (int'(cmd[c].intf_id) == t) tgt_free[c] = slot_free[t];
      end
    end
  end

  always_comb begin
    req_gnt     = '0;
    req_any     = 1'b0;
    rr_req_next = rr_req_reg;
    for (int i = 0; i < N_CLUSTERS; i++) begin
      for (int c = 0; c < N_CLUSTERS; c++) begin
        if (!req_any && c == rr_idx(int'(rr_req_reg), i, N_CLUSTERS) && req_elig[c]) begin
          req_any     = 1'b1;
          req_gnt[c]  = 1'b1;
          rr_req_next = RQ_W'(rr_idx(c, 1, N_CLUSTERS));
        end
      end
    end
    gnt_cmd = '0;
    gnt_bad = 1'b0;
    for (int c = 0; c < N_CLUSTERS; c++) begin
      if (req_gnt[c]) begin
        gnt_cmd = cmd[c];
        gnt_bad = req_bad[c];
      end
    end
  end

  assign cmd_ready_o = req_gnt;

  // Per-interface slots; a drain and a reload may coincide.
  for (genvar gi = 0; gi < N_INTF; gi++) begin : g_slot
    pspin_cmd_t slot_cmd_reg;
    logic       slot_valid_reg;
    logic       load;
    assign load = req_any & ~gnt_bad & (int'(gnt_cmd.intf_id) == gi);
    assign slot_valid[gi]   = slot_valid_reg;
    assign intf_valid_o[gi] = slot_valid_reg;
    assign intf_cmd_o[gi*CMD_W +: CMD_W] = slot_cmd_reg;
    assign resp_in[gi] = intf_resp_i[gi*RSP_W +: RSP_W];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        slot_valid_reg <= 1'b0;
        slot_cmd_reg   <= '0;
      end else if (load) begin
        slot_valid_reg <= 1'b1;
        slot_cmd_reg   <= gnt_cmd;
      end else if (intf_ready_i[gi]) begin
        slot_valid_reg <= 1'b0;
      end
    end
  end

  // Response stage: only accepts when empty or draining, so a stalled cluster blocks all.
  assign rsp_drain = |(rsp_vec_reg & clu_resp_ready_i);
  assign rsp_free  = ~(|rsp_vec_reg) | rsp_drain;

  always_comb begin
    rsp_gnt     = '0;
    rsp_any     = 1'b0;
    rr_rsp_next = rr_rsp_reg;
    rsp_sel     = '0;
    for (int i = 0; i < N_INTF; i++) begin
      for (int t = 0; t < N_INTF; t++) begin
        if (rsp_free && !rsp_any && t == rr_idx(int'(rr_rsp_reg), i, N_INTF) &&
            intf_resp_valid_i[t]) begin
          rsp_any     = 1'b1;
          rsp_gnt[t]  = 1'b1;
          rsp_sel     = resp_in[t];
          rr_rsp_next = RS_W'(rr_idx(t, 1, N_INTF));
        end
      end
    end
    rsp_sel_bad = int'(rsp_sel.cmd_id.cluster_id) >= N_CLUSTERS;
    rsp_onehot  = '0;
    for (int c = 0; c < N_CLUSTERS; c++) begin
      if (int'(rsp_sel.cmd_id.cluster_id) == c) rsp_onehot[c] = 1'b1;
    end
  end

  assign intf_resp_ready_o = rsp_gnt;
  assign clu_resp_valid_o  = rsp_vec_reg;
  assign clu_resp_o        = rsp_reg;
  assign err_bad_intf_o    = err_bad_intf_reg;
  assign err_bad_cluster_o = err_bad_cluster_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_req_reg          <= '0;
      rr_rsp_reg          <= '0;
      rsp_vec_reg         <= '0;
      rsp_reg             <= '0;
      err_bad_intf_reg    <= 1'b0;
      err_bad_cluster_reg <= 1'b0;
    end else begin
      rr_req_reg          <= rr_req_next;
      rr_rsp_reg          <= rr_rsp_next;
      err_bad_intf_reg    <= req_any & gnt_bad;
      err_bad_cluster_reg <= (rsp_any & rsp_sel_bad) | (|underflow);
      if (rsp_any && !rsp_sel_bad) begin
        rsp_vec_reg <= rsp_onehot;
        rsp_reg     <= rsp_sel;
      end else if (rsp_drain) begin
        rsp_vec_reg <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pspin_cmd_dispatcher.sv
// Directed bench for pspin_cmd_dispatcher: arbitration, slots, credits, completions, errors.
module tb_pspin_cmd_dispatcher;
  import pspin_cfg_pkg::*;
  localparam int CW  = $bits(pspin_cmd_t);
  localparam int RW  = $bits(pspin_cmd_resp_t);

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [1:0]    cmd_valid_i = '0;
  logic [1:0]    cmd_ready_o;
  logic [2*CW-1:0] cmd_i = '0;
  logic [2:0]    intf_valid_o;
  logic [2:0]    intf_ready_i = '0;
  logic [3*CW-1:0] intf_cmd_o;
  logic [2:0]    intf_resp_valid_i = '0;
  logic [2:0]    intf_resp_ready_o;
  logic [3*RW-1:0] intf_resp_i = '0;
  logic [1:0]    clu_resp_valid_o;
  logic [1:0]    clu_resp_ready_i = '0;
  logic [RW-1:0] clu_resp_o;
  logic [11:0]   inflight_o;
  logic          err_bad_intf_o, err_bad_cluster_o;

  int total = 0;
  int bad = 0;

  pspin_cmd_dispatcher dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_i(cmd_i),
    .intf_valid_o(intf_valid_o), .intf_ready_i(intf_ready_i), .intf_cmd_o(intf_cmd_o),
    .intf_resp_valid_i(intf_resp_valid_i), .intf_resp_ready_o(intf_resp_ready_o),
    .intf_resp_i(intf_resp_i),
    .clu_resp_valid_o(clu_resp_valid_o), .clu_resp_ready_i(clu_resp_ready_i),
    .clu_resp_o(clu_resp_o), .inflight_o(inflight_o),
    .err_bad_intf_o(err_bad_intf_o), .err_bad_cluster_o(err_bad_cluster_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic pspin_cmd_t mk_cmd(input logic [1:0] clu, input logic [1:0] intf,
                                        input logic [31:0] d);
    pspin_cmd_t c;
    c.cmd_id.cluster_id = clu;
    c.cmd_id.core_id    = 4'h5;
    c.cmd_id.local_id   = 2'd1;
    c.intf_id           = intf;
    c.descr             = d;
    return c;
  endfunction

  function automatic pspin_cmd_resp_t mk_rsp(input logic [1:0] clu, input logic [7:0] st);
    pspin_cmd_resp_t r;
    r.cmd_id.cluster_id = clu;
    r.cmd_id.core_id    = 4'h3;
    r.cmd_id.local_id   = 2'd2;
    r.status            = st;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    $display("check %s got=%h exp=%h", tag, got, exp);
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  pspin_cmd_t c0a, c0b, c1a, c1b, c0c, c0bad;
  pspin_cmd_resp_t r0a, r0b, r1a, r0c, rbad;

  initial begin
    c0a = mk_cmd(2'd0, 2'd1, 32'hA000_0001);
    c0b = mk_cmd(2'd0, 2'd2, 32'hB000_0002);
    c1a = mk_cmd(2'd1, 2'd2, 32'hC000_0003);
    c0c = mk_cmd(2'd0, 2'd0, 32'hD000_0004);
    c1b = mk_cmd(2'd1, 2'd0, 32'hE000_0005);
    c0bad = mk_cmd(2'd1, 2'd3, 32'hF000_0006);
    r0a = mk_rsp(2'd0, 8'h11);
    r0b = mk_rsp(2'd0, 8'h22);
    r1a = mk_rsp(2'd1, 8'h33);
    r0c = mk_rsp(2'd0, 8'h44);
    rbad = mk_rsp(2'd2, 8'h55);

    // Reset state
    tick(); tick();
    chk("rst_intf_valid", 64'(intf_valid_o), 64'd0);
    chk("rst_inflight", 64'(inflight_o), 64'd0);
    chk("rst_clu_valid", 64'(clu_resp_valid_o), 64'd0);
    chk("rst_errs", 64'({err_bad_intf_o, err_bad_cluster_o}), 64'd0);
    rst_ni = 1'b1;
    tick();

    // Single command: cluster 0 -> intf 1
    intf_ready_i = 3'b111;
    cmd_i[0 +: CW] = c0a;
    cmd_valid_i = 2'b01;
    #1 chk("single_ready", 64'(cmd_ready_o), 64'b01);
    tick();
    cmd_valid_i = 2'b00;
    chk("single_valid", 64'(intf_valid_o), 64'b010);
    chk("single_payload", 64'(intf_cmd_o[CW +: CW]), 64'(c0a));
    chk("single_inflight0", 64'(inflight_o[5:0]), 64'd1);
    tick();
    chk("single_drained", 64'(intf_valid_o), 64'b000);

    // Fairness on intf 2 (pointer now at cluster 1)
    cmd_i[0 +: CW] = c0b;
    cmd_i[CW +: CW] = c1a;
    cmd_valid_i = 2'b11;
    #1 chk("fair_g1", 64'(cmd_ready_o), 64'b10);
    tick();
    chk("fair_g2", 64'(cmd_ready_o), 64'b01);
    chk("fair_slot_c1", 64'(intf_cmd_o[2*CW +: CW]), 64'(c1a));
    tick();
    chk("fair_g3", 64'(cmd_ready_o), 64'b10);
    chk("fair_slot_c0", 64'(intf_cmd_o[2*CW +: CW]), 64'(c0b));
    tick();
    chk("fair_g4", 64'(cmd_ready_o), 64'b01);
    tick();
    cmd_valid_i = 2'b00;
    chk("fair_inflight", 64'(inflight_o), 64'({6'd2, 6'd3}));
    tick();
    chk("fair_drained", 64'(intf_valid_o), 64'b000);

    // Backpressure on intf 0
    intf_ready_i = 3'b110;
    cmd_i[0 +: CW] = c0c;
    cmd_valid_i = 2'b01;
    #1 chk("bp_fill", 64'(cmd_ready_o), 64'b01);
    tick();
    cmd_i[0 +: CW] = c0b;
    cmd_i[CW +: CW] = c1b;
    cmd_valid_i = 2'b11;
    #1 chk("bp_c0_only", 64'(cmd_ready_o), 64'b01);
    tick();
    cmd_valid_i = 2'b10;
    #1 chk("bp_c1_stall", 64'(cmd_ready_o), 64'b00);
    chk("bp_valids", 64'(intf_valid_o), 64'b101);
    tick();
    chk("bp_still_stall", 64'(cmd_ready_o), 64'b00);
    chk("bp_slot0_held", 64'(intf_cmd_o[0 +: CW]), 64'(c0c));
    intf_ready_i = 3'b111;
    #1 chk("bp_release", 64'(cmd_ready_o), 64'b10);
    tick();
    cmd_valid_i = 2'b00;
    chk("bp_reload_valid", 64'(intf_valid_o), 64'b001);
    chk("bp_reload_cmd", 64'(intf_cmd_o[0 +: CW]), 64'(c1b));
    tick();
    chk("bp_inflight", 64'(inflight_o), 64'({6'd3, 6'd5}));

    // Credit limit: cluster 0 from 5 up to 32
    cmd_i[0 +: CW] = c0a;
    cmd_valid_i = 2'b01;
    for (int i = 0; i < 27; i++) tick();
    chk("cred_full", 64'(inflight_o[5:0]), 64'd32);
    chk("cred_blocked", 64'(cmd_ready_o), 64'b00);
    tick();
    chk("cred_33rd", 64'(inflight_o[5:0]), 64'd32);
    clu_resp_ready_i = 2'b11;
    intf_resp_i[RW +: RW] = r0a;
    intf_resp_valid_i = 3'b010;
    #1 chk("cred_rsp_acc", 64'(intf_resp_ready_o), 64'b010);
    tick();
    intf_resp_valid_i = 3'b000;
    chk("cred_rsp_valid", 64'(clu_resp_valid_o), 64'b01);
    chk("cred_rsp_data", 64'(clu_resp_o), 64'(r0a));
    chk("cred_still_blk", 64'(cmd_ready_o), 64'b00);
    tick();
    chk("cred_regrant", 64'(cmd_ready_o), 64'b01);
    chk("cred_31", 64'(inflight_o[5:0]), 64'd31);
    tick();
    cmd_valid_i = 2'b00;
    chk("cred_back32", 64'(inflight_o[5:0]), 64'd32);

    // Completion routing: intf1->cluster1, intf2->cluster0, pointer at intf 2
    clu_resp_ready_i = 2'b01;
    intf_resp_i[RW +: RW] = r1a;
    intf_resp_i[2*RW +: RW] = r0b;
    intf_resp_valid_i = 3'b110;
    #1 chk("rt_first", 64'(intf_resp_ready_o), 64'b100);
    tick();
    intf_resp_valid_i = 3'b010;
    chk("rt_c0_valid", 64'(clu_resp_valid_o), 64'b01);
    chk("rt_c0_data", 64'(clu_resp_o), 64'(r0b));
    chk("rt_second", 64'(intf_resp_ready_o), 64'b010);
    tick();
    intf_resp_valid_i = 3'b000;
    chk("rt_c1_valid", 64'(clu_resp_valid_o), 64'b10);
    chk("rt_c1_data", 64'(clu_resp_o), 64'(r1a));
    tick();
    chk("rt_c1_stall", 64'(clu_resp_valid_o), 64'b10);
    intf_resp_i[0 +: RW] = r0c;
    intf_resp_valid_i = 3'b001;
    #1 chk("rt_hol_block", 64'(intf_resp_ready_o), 64'b000);
    clu_resp_ready_i = 2'b11;
    #1 chk("rt_unblock", 64'(intf_resp_ready_o), 64'b001);
    tick();
    intf_resp_valid_i = 3'b000;
    chk("rt_c0_again", 64'(clu_resp_valid_o), 64'b01);
    tick();
    chk("rt_empty", 64'(clu_resp_valid_o), 64'b00);
    chk("rt_inflight", 64'(inflight_o), 64'({6'd2, 6'd30}));

    // Bad interface id
    cmd_i[CW +: CW] = c0bad;
    cmd_valid_i = 2'b10;
    #1 chk("badi_ready", 64'(cmd_ready_o), 64'b10);
    tick();
    cmd_valid_i = 2'b00;
    chk("badi_pulse", 64'(err_bad_intf_o), 64'd1);
    chk("badi_no_slot", 64'(intf_valid_o), 64'b000);
    chk("badi_inflight", 64'(inflight_o), 64'({6'd2, 6'd30}));
    tick();
    chk("badi_pulse_end", 64'(err_bad_intf_o), 64'd0);

    // Bad cluster id
    intf_resp_i[0 +: RW] = rbad;
    intf_resp_valid_i = 3'b001;
    #1 chk("badc_acc", 64'(intf_resp_ready_o), 64'b001);
    tick();
    intf_resp_valid_i = 3'b000;
    chk("badc_pulse", 64'(err_bad_cluster_o), 64'd1);
    chk("badc_dropped", 64'(clu_resp_valid_o), 64'b00);
    tick();
    chk("badc_pulse_end", 64'(err_bad_cluster_o), 64'd0);

    // Reset with a full slot
    intf_ready_i = 3'b000;
    cmd_i[0 +: CW] = c0c;
    cmd_valid_i = 2'b01;
    tick();
    cmd_valid_i = 2'b00;
    chk("rst2_full", 64'(intf_valid_o), 64'b001);
    #2 rst_ni = 1'b0;
    #1 chk("rst2_valid", 64'(intf_valid_o), 64'b000);
    chk("rst2_inflight", 64'(inflight_o), 64'd0);
    tick();
    #2 rst_ni = 1'b1;
    tick();
    chk("rst2_after", 64'(intf_valid_o), 64'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
